// File: rtl/pwm_pkg.sv
// Shared types and constants for the phased PWM array.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PERIOD_40K = 1250;
    localparam int DUTY_HALF  = PERIOD_40K / 2;
    // Config fields are sized for the longest supported period; unused upper bits stay zero.
    localparam int CFG_W      = 16;

    typedef struct packed {
        logic [CFG_W-1:0] phase;
        logic [CFG_W-1:0] duty;
        logic             en;
    } ch_cfg_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_st_e;

    function automatic ch_cfg_t cfg_reset(input int duty_rst);
        return '{phase: '0, duty: CFG_W'(duty_rst), en: 1'b0};
    endfunction

endpackage

// File: rtl/phased_pwm_array_if.sv
// Config/commit/calibration bus and PWM outputs of the phased PWM array.
// Latency: n/a (wires only).
// Backpressure: none; master strobes, slave answers with registered pulses.
interface phased_pwm_array_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = $clog2(pwm_pkg::PERIOD_40K)
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_phase;
    logic [CNT_W-1:0]  cfg_duty;
    logic              cfg_en;
    logic              cfg_err;
    logic              commit;
    logic              commit_pending;
    logic              commit_done;
    logic              calib_en;
    logic              sync_out;
    logic [NUM_CH-1:0] trans;

    modport master (
        output cfg_valid, cfg_ch, cfg_phase, cfg_duty, cfg_en, commit, calib_en,
        input  cfg_err, commit_pending, commit_done, sync_out, trans
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_phase, cfg_duty, cfg_en, commit, calib_en,
        output cfg_err, commit_pending, commit_done, sync_out, trans
    );

endinterface

// File: rtl/phased_pwm_channel.sv
// One transducer channel: active config register, wrap-safe phase compare, output flop.
// Latency: trans follows the shared counter by one cycle; active config loads on load.
// Backpressure: none.
module phased_pwm_channel
    import pwm_pkg::*;
#(
    parameter int PERIOD   = PERIOD_40K,
    parameter int CNT_W    = $clog2(PERIOD),
    parameter int DUTY_RST = PERIOD / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  ch_cfg_t          shadow,
    output logic             trans
);
    localparam int XW = CFG_W + 1;

    ch_cfg_t       act_q, act_d;
    logic          trans_q, trans_d;
    logic [XW-1:0] cnt_x, phase_x, diff;

    always_comb begin
        act_d   = load ? shadow : act_q;
        cnt_x   = XW'(cnt);
        phase_x = {1'b0, act_q.phase};
        // Phase is always below PERIOD, so both branches land in 0..PERIOD-1.
        diff    = (cnt_x >= phase_x) ? (cnt_x - phase_x) : (cnt_x + XW'(PERIOD) - phase_x);
        trans_d = act_q.en && (diff < {1'b0, act_q.duty});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= cfg_reset(DUTY_RST);
            trans_q <= 1'b0;
        end else begin
            act_q   <= act_d;
            trans_q <= trans_d;
        end
    end

    assign trans = trans_q;

endmodule

// File: rtl/phased_pwm_array.sv
// N-channel phased square-wave generator, shadow config committed at the period wrap (SYNC_LOCK_EN adds sync_in).
// Latency: trans one cycle behind the counter; cfg_err/commit_done/sync_out registered one cycle after cause.
// Backpressure: none; every cfg write is taken or rejected with cfg_err, commit is idempotent while pending.
module phased_pwm_array
    import pwm_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PERIOD   = PERIOD_40K,
    parameter int CNT_W    = $clog2(PERIOD),
    parameter int DUTY_RST = PERIOD / 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SYNC_LOCK_EN
    input  logic              sync_in,
`endif
    phased_pwm_array_if.slave bus
);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              sync_out_q, sync_out_d;
    logic              cfg_err_q, cfg_err_d;
    logic              commit_done_q, commit_done_d;
    commit_st_e        st_q, st_d;
    ch_cfg_t           shadow_q [NUM_CH];
    ch_cfg_t           shadow_d [NUM_CH];
    logic              wrap, realign, sync_edge, cfg_ok, apply;
    logic [NUM_CH-1:0] trans;

`ifdef SYNC_LOCK_EN
    logic [1:0] sync_ff_q, sync_ff_d;
    logic       sync_prev_q, sync_prev_d;

    always_comb begin
        sync_ff_d   = {sync_ff_q[0], sync_in};
        sync_prev_d = sync_ff_q[1];
        sync_edge   = sync_ff_q[1] & ~sync_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff_q   <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_ff_q   <= sync_ff_d;
            sync_prev_q <= sync_prev_d;
        end
    end
`else
    assign sync_edge = 1'b0;
`endif

    always_comb begin
        run_d    = 1'b1;
        wrap     = run_q && (cnt_q == CNT_W'(PERIOD - 1));
        realign  = bus.calib_en | sync_edge;
        // The first edge after reset only arms the counter, so count 0 is shown with sync_out.
        if (!run_q || wrap || realign) cnt_d = '0;
        else                           cnt_d = cnt_q + CNT_W'(1);
        sync_out_d = (cnt_d == '0);

        cfg_ok    = (32'(bus.cfg_ch) < NUM_CH) && (32'(bus.cfg_phase) < PERIOD);
        cfg_err_d = bus.cfg_valid && !cfg_ok;
        shadow_d  = shadow_q;
        if (bus.cfg_valid && cfg_ok) begin
            shadow_d[bus.cfg_ch] = '{phase: CFG_W'(bus.cfg_phase),
                                     duty:  CFG_W'(bus.cfg_duty),
                                     en:    bus.cfg_en};
        end

        st_d  = st_q;
        apply = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (bus.commit) begin
                    if (wrap || realign) apply = 1'b1;
                    else                 st_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (wrap || realign) begin
                    apply = 1'b1;
                    st_d  = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        commit_done_d = apply;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            run_q         <= 1'b0;
            sync_out_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            commit_done_q <= 1'b0;
            st_q          <= ST_IDLE;
            shadow_q      <= '{default: cfg_reset(DUTY_RST)};
        end else begin
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            sync_out_q    <= sync_out_d;
            cfg_err_q     <= cfg_err_d;
            commit_done_q <= commit_done_d;
            st_q          <= st_d;
            shadow_q      <= shadow_d;
        end
    end

    // Shadow is sampled pre-write, so a write on the commit edge waits for the next commit.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        phased_pwm_channel #(
            .PERIOD  (PERIOD),
            .CNT_W   (CNT_W),
            .DUTY_RST(DUTY_RST)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .cnt   (cnt_q),
            .load  (apply),
            .shadow(shadow_q[i]),
            .trans (trans[i])
        );
    end

    assign bus.trans          = trans;
    assign bus.sync_out       = sync_out_q;
    assign bus.cfg_err        = cfg_err_q;
    assign bus.commit_done    = commit_done_q;
    assign bus.commit_pending = (st_q == ST_PENDING);

endmodule
